sha256_msg_schedule: RTL and testbench

Upstream feeder for the SHA-256 round stage (main_loop). It accepts one 512-bit message block and streams the 64 (W_t, K_t) pairs to the round stage, one per accepted beat, in round order 0..63. W_t is expanded on the fly with a 16-word sliding window. K_t comes from an internal 64-entry constant ROM.

---
 rtl/sha256_msg_schedule.sv | 117 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule feeder: loads one 512-bit block and streams 64 (W_t, K_t) beats in round order.
// Optional macro SCHED_BACKPRESSURE_EN adds the w_ready input; without it every RUN cycle consumes a beat.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [511:0]      block_in,
`ifdef SCHED_BACKPRESSURE_EN
    input  logic              w_ready,
`endif
    output logic              w_valid,
    output logic [WORD_W-1:0] w_out,
    output logic [WORD_W-1:0] k_out,
    output logic [5:0]        round_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WORD_W-1:0] K_ROM [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t            state_q, state_d;
    logic [WORD_W-1:0] window [0:15];
    logic [WORD_W-1:0] new_word;
    logic              ready;
    logic              accept;
    logic              last_beat;
    logic              load;

`ifdef SCHED_BACKPRESSURE_EN
    assign ready = w_ready;
`else
    assign ready = 1'b1;
`endif

    // Handshake: a beat transfers on a rising edge where w_valid && ready; w_valid never
    // drops and beat contents never change while a beat is offered but not taken.
    assign accept    = (state_q == RUN) && ready;
    assign last_beat = (round_idx == 6'(ROUNDS - 1));
    assign new_word  = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_idx <= '0;
            done      <= 1'b0;
            for (int i = 0; i < 16; i++) window[i] <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                round_idx <= '0;
                for (int i = 0; i < 16; i++) window[i] <= block_in[511 - 32*i -: 32];
            end else if (accept) begin
                if (last_beat) begin
                    round_idx <= '0;
                    done      <= 1'b1;
                end else begin
                    round_idx <= round_idx + 6'd1;
                    for (int i = 0; i < 15; i++) window[i] <= window[i+1];
                    window[15] <= new_word;
                end
            end
        end
    end

    // Outputs are gated so an idle schedule presents all zeros to the round stage.
    assign w_valid = (state_q == RUN);
    assign busy    = (state_q == RUN);
    assign w_out   = w_valid ? window[0] : '0;
    assign k_out   = w_valid ? K_ROM[round_idx] : '0;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: reference W expansion feeds an expected-beat queue.
// Backpressure scenario runs only when SCHED_BACKPRESSURE_EN is defined.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic         w_ready;
    logic         w_valid;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   round_idx;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    logic [69:0] exp_q[$];

    localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .block_in  (block_in),
`ifdef SCHED_BACKPRESSURE_EN
        .w_ready   (w_ready),
`endif
        .w_valid   (w_valid),
        .w_out     (w_out),
        .k_out     (k_out),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic push_block(input logic [511:0] blk);
        logic [31:0] w [0:63];
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), w[t], K_TAB[t]});
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the loading edge.
    task automatic drive_start(input logic [511:0] blk, input bit expect_load);
        start    = 1'b1;
        block_in = blk;
        if (expect_load) push_block(blk);
        @(negedge clk);
        start    = 1'b0;
        block_in = {16{$urandom()}};
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        rst = 1'b0; start = 1'b0; w_ready = 1'b1; block_in = '0;
        #1;
        checks++;
        if ({w_valid, busy, done, round_idx, w_out, k_out} !== 73'd0) begin
            errors++; $display("FAIL reset_initial got=%h required=0", {w_valid, busy, done, round_idx, w_out, k_out});
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        drive_start(ABC_BLOCK, 1'b1);
        for (n = 0; n < 5; n++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({w_valid, busy, done, round_idx, w_out, k_out} !== 73'd0) begin
            errors++; $display("FAIL reset_async got=%h required=0", {w_valid, busy, done, round_idx, w_out, k_out});
        end
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (w_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_idle cyc=%0d w_valid=%b busy=%b done=%b required 0", i, w_valid, busy, done);
            end
        end
    endtask

    task automatic test_abc();
        int n = 0;
        int cyc = 0;
        logic [69:0] got, exp;
        drive_start(ABC_BLOCK, 1'b1);
        while (n < 64 && cyc < 200) begin
            if (w_valid) begin
                got = {round_idx, w_out, k_out};
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL abc_beat t=%0d got=%h required=%h", n, got, exp); end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abc_flags t=%0d busy=%b done=%b required 1/0", n, busy, done); end
                if (n == 0) begin
                    checks++;
                    if (w_out !== 32'h61626380 || k_out !== 32'h428a2f98) begin
                        errors++; $display("FAIL abc_t0 got=%h/%h required=61626380/428a2f98", w_out, k_out);
                    end
                end
                if (n == 15 || n == 16 || n == 17) begin
                    checks++;
                    exp[31:0] = (n == 15) ? 32'h00000018 : (n == 16) ? 32'h61626380 : 32'h000f0000;
                    if (w_out !== exp[31:0]) begin errors++; $display("FAIL abc_t%0d got=%h required=%h", n, w_out, exp[31:0]); end
                end
                if (n == 63) begin
                    checks++;
                    if (w_out !== 32'h12b1edeb || k_out !== 32'hc67178f2) begin
                        errors++; $display("FAIL abc_t63 got=%h/%h required=12b1edeb/c67178f2", w_out, k_out);
                    end
                end
                n++;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL abc_timeout beats=%0d required=64", n); end
        checks++;
        if (done !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0 || round_idx !== 6'd0) begin
            errors++; $display("FAIL abc_done done=%b w_valid=%b busy=%b idx=%0d required 1/0/0/0", done, w_valid, busy, round_idx);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL abc_done_width done=%b required=0", done); end
    endtask

`ifdef SCHED_BACKPRESSURE_EN
    task automatic test_backpressure();
        int n = 0;
        int cyc = 0;
        int stall = 0;
        logic [69:0] got, exp;
        drive_start(ABC_BLOCK, 1'b1);
        while (n < 64 && cyc < 200) begin
            got = {round_idx, w_out, k_out};
            if (n == 20 && stall < 3) begin
                w_ready = 1'b0;
                checks++;
                if (w_valid !== 1'b1 || got !== exp_q[0]) begin
                    errors++; $display("FAIL bp_hold stall=%0d got=%h required=%h", stall, got, exp_q[0]);
                end
                stall++;
            end else begin
                w_ready = 1'b1;
                if (w_valid) begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (got !== exp) begin errors++; $display("FAIL bp_beat t=%0d got=%h required=%h", n, got, exp); end
                    n++;
                end
            end
            @(negedge clk); cyc++;
        end
        w_ready = 1'b1;
        checks++;
        if (n != 64 || done !== 1'b1) begin errors++; $display("FAIL bp_end beats=%0d done=%b required 64/1", n, done); end
        @(negedge clk);
    endtask
`endif

    task automatic test_start_ignored();
        int n = 0;
        int cyc = 0;
        logic [69:0] got, exp;
        drive_start(ABC_BLOCK, 1'b1);
        while (n < 64 && cyc < 200) begin
            start = (n == 30);
            if (n == 30) block_in = rand_block();
            if (w_valid) begin
                got = {round_idx, w_out, k_out};
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL ign_beat t=%0d got=%h required=%h", n, got, exp); end
                n++;
            end
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        checks++;
        if (n != 64 || done !== 1'b1) begin errors++; $display("FAIL ign_end beats=%0d done=%b required 64/1", n, done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int cyc = 0;
        logic [69:0] got, exp;
        logic [511:0] blk_b;
        blk_b = rand_block();
        drive_start(rand_block(), 1'b1);
        while (n < 128 && cyc < 400) begin
            if (n == 64) begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("FAIL b2b_done done=%b required=1", done); end
                drive_start(blk_b, 1'b1);
                checks++;
                if (w_valid !== 1'b1 || round_idx !== 6'd0 || w_out !== blk_b[511:480] || k_out !== 32'h428a2f98) begin
                    errors++; $display("FAIL b2b_first got=%b/%0d/%h/%h required 1/0/%h/428a2f98", w_valid, round_idx, w_out, k_out, blk_b[511:480]);
                end
            end
            if (w_valid) begin
                got = {round_idx, w_out, k_out};
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL b2b_beat n=%0d got=%h required=%h", n, got, exp); end
                n++;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (n != 128 || done !== 1'b1) begin errors++; $display("FAIL b2b_end beats=%0d done=%b required 128/1", n, done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_block();
        int n = 0;
        int cyc = 0;
        logic [69:0] got, exp;
        drive_start(ABC_BLOCK, 1'b1);
        while (n < 40 && cyc < 200) begin
            if (w_valid) begin void'(exp_q.pop_front()); n++; end
            @(negedge clk); cyc++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset w_valid=%b busy=%b done=%b required 0", w_valid, busy, done);
        end
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("FAIL mid_nodone cyc=%0d done=%b w_valid=%b required 0", i, done, w_valid); end
        end
        n = 0; cyc = 0;
        drive_start(ABC_BLOCK, 1'b1);
        while (n < 64 && cyc < 200) begin
            if (w_valid) begin
                got = {round_idx, w_out, k_out};
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL mid_restart t=%0d got=%h required=%h", n, got, exp); end
                n++;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (n != 64 || done !== 1'b1) begin errors++; $display("FAIL mid_end beats=%0d done=%b required 64/1", n, done); end
        @(negedge clk);
    endtask

    task automatic test_random_blocks();
        int n;
        int cyc;
        logic [69:0] got, exp;
        for (int b = 0; b < 3; b++) begin
            n = 0; cyc = 0;
            drive_start(rand_block(), 1'b1);
            while (n < 64 && cyc < 200) begin
                if (w_valid) begin
                    got = {round_idx, w_out, k_out};
                    exp = exp_q.pop_front();
                    checks++;
                    if (got !== exp) begin errors++; $display("FAIL rand_beat blk=%0d t=%0d got=%h required=%h", b, n, got, exp); end
                    n++;
                end
                @(negedge clk); cyc++;
            end
            checks++;
            if (n != 64 || done !== 1'b1) begin errors++; $display("FAIL rand_end blk=%0d beats=%0d done=%b", b, n, done); end
            for (int i = 0; i < $urandom_range(0, 3); i++) @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_abc();
`ifdef SCHED_BACKPRESSURE_EN
        test_backpressure();
`endif
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_block();
        test_random_blocks();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected size=%0d required=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
